// File: rtl/board_renderer_if.sv
// board_renderer_if: pixel-plot bus between the board renderer and the VGA adapter
interface board_renderer_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       ready;
  modport master (output x, y, colour, plot, input ready);
  modport slave  (input x, y, colour, plot, output ready);
endinterface

// File: rtl/board_renderer.sv
// board_renderer: snapshots the 200-cell board on start and streams it as CELL_SIZE x CELL_SIZE pixel blocks
module board_renderer #(
  parameter int       CELL_SIZE    = 4,
  parameter int       X_ORIGIN     = 60,
  parameter int       Y_ORIGIN     = 20,
  parameter logic [2:0] FILL_COLOUR  = 3'b111,
  parameter logic [2:0] EMPTY_COLOUR = 3'b000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [199:0]        board,
  board_renderer_if.master    pix,
  output logic                busy,
  output logic                done
);
  if (CELL_SIZE < 1 || CELL_SIZE > 8 || (CELL_SIZE & (CELL_SIZE - 1)) != 0) begin : g_bad_cell
    $error("CELL_SIZE must be a power of 2 in 1..8");
  end
  if (X_ORIGIN + 10 * CELL_SIZE > 160 || Y_ORIGIN + 20 * CELL_SIZE > 120) begin : g_bad_origin
    $error("board does not fit on the 160x120 screen");
  end
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  localparam logic [2:0] CS_M1 = 3'(CELL_SIZE - 1);
  state_t        state_q, state_d;
  logic [2:0]    px_q, px_d, py_q, py_d;
  logic [3:0]    col_q, col_d;
  logic [4:0]    row_q, row_d;
  logic [199:0]  snap_q, snap_d;
  logic          acc, px_end, py_end, col_end, row_end, last;
  logic [7:0]    idx;
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  // scan counters and board snapshot
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      px_q   <= '0;
      py_q   <= '0;
      col_q  <= '0;
      row_q  <= '0;
      snap_q <= '0;
    end else begin
      px_q   <= px_d;
      py_q   <= py_d;
      col_q  <= col_d;
      row_q  <= row_d;
      snap_q <= snap_d;
    end
  // next state: a frame ends once the bottom-right pixel is accepted
  always_comb begin
    acc     = (state_q == DRAW) && pix.ready;
    px_end  = px_q == CS_M1;
    py_end  = py_q == CS_M1;
    col_end = col_q == 4'd9;
    row_end = row_q == 5'd19;
    last    = row_end && col_end && py_end && px_end;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? DRAW : IDLE;
      DRAW:    state_d = (acc && last) ? DONE : DRAW;
      default: state_d = IDLE;
    endcase
  end
  // counter advance, px fastest, row slowest; start clears and snapshots
  always_comb begin
    px_d   = px_q;
    py_d   = py_q;
    col_d  = col_q;
    row_d  = row_q;
    snap_d = snap_q;
    if (state_q == IDLE && start) begin
      px_d   = '0;
      py_d   = '0;
      col_d  = '0;
      row_d  = '0;
      snap_d = board;
    end else if (acc) begin
      px_d = px_end ? 3'd0 : px_q + 3'd1;
      if (px_end) begin
        py_d = py_end ? 3'd0 : py_q + 3'd1;
        if (py_end) begin
          col_d = col_end ? 4'd0 : col_q + 4'd1;
          if (col_end) row_d = row_end ? 5'd0 : row_q + 5'd1;
        end
      end
    end
  end
  // pixel outputs decoded from the registered counters; zero outside DRAW
  always_comb begin
    idx        = 8'(row_q) * 8'd10 + 8'(col_q);
    pix.plot   = state_q == DRAW;
    pix.x      = pix.plot ? 8'(9'(X_ORIGIN) + 9'(col_q) * 9'(CELL_SIZE) + 9'(px_q)) : 8'd0;
    pix.y      = pix.plot ? 7'(9'(Y_ORIGIN) + 9'(row_q) * 9'(CELL_SIZE) + 9'(py_q)) : 7'd0;
    pix.colour = pix.plot ? (snap_q[idx] ? FILL_COLOUR : EMPTY_COLOUR) : 3'd0;
    busy       = state_q != IDLE;
    done       = state_q == DONE;
  end
endmodule

// File: tb/tb_board_renderer.sv
// tb_board_renderer: pixel-index reference model plus directed frame scenarios for board_renderer
module tb_board_renderer;
  localparam int CS   = 4;
  localparam int NPIX = 200 * CS * CS;
  logic clk = 0, resetn = 0, start = 0;
  logic [199:0] board = '0;
  logic busy, done;
  board_renderer_if pix();
  board_renderer dut (.clk(clk), .resetn(resetn), .start(start), .board(board), .pix(pix), .busy(busy), .done(done));
  always #5 clk = ~clk;
  int pass_cnt = 0, chk_cnt = 0;
  int ph = 0, n = 0;
  logic [199:0] m_snap = '0;
  int s_plots, s_plot_cyc, s_busy, s_done_cyc, s_fill, s_fill_first, s_fill_last, s_dup;
  int s_fx, s_fy, s_lx, s_ly;
  int done_total = 0;
  bit seen [160][120];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  function automatic int exp_x(input int i);
    return 60 + ((i / (CS * CS)) % 10) * CS + i % CS;
  endfunction
  function automatic int exp_y(input int i);
    return 20 + ((i / (CS * CS)) / 10) * CS + (i % (CS * CS)) / CS;
  endfunction
  // reference model and frame statistics, sampled mid-cycle
  always @(negedge clk) begin
    if (!resetn) begin
      chk("reset_outputs", 64'({pix.plot, busy, done, pix.x, pix.y, pix.colour}), 64'd0);
      ph = 0;
    end else begin
      if (busy) s_busy++;
      if (pix.plot) s_plot_cyc++;
      if (done) begin
        done_total++;
        s_done_cyc = s_busy;
      end
      if (pix.plot && pix.ready) begin
        if (s_plots == 0) begin
          s_fx = int'(pix.x);
          s_fy = int'(pix.y);
        end
        s_lx = int'(pix.x);
        s_ly = int'(pix.y);
        if (pix.colour == 3'b111) begin
          s_fill++;
          if (s_fill_first < 0) s_fill_first = s_plots;
          s_fill_last = s_plots;
        end
        if (pix.x < 160 && pix.y < 120) begin
          if (seen[pix.x][pix.y]) s_dup++;
          seen[pix.x][pix.y] = 1'b1;
        end
        s_plots++;
      end
      case (ph)
        0: begin
          chk("idle_flags", 64'({pix.plot, busy, done}), 64'd0);
          if (start) begin
            ph = 1; n = 0; m_snap = board;
            s_plots = 0; s_plot_cyc = 0; s_busy = 0; s_done_cyc = 0; s_fill = 0;
            s_fill_first = -1; s_fill_last = -1; s_dup = 0;
            s_fx = -1; s_fy = -1; s_lx = -1; s_ly = -1;
            seen = '{default: '{default: 1'b0}};
          end
        end
        1: begin
          chk("draw_pixel", 64'({pix.plot, busy, done, pix.x, pix.y, pix.colour}),
              64'({3'b110, 8'(exp_x(n)), 7'(exp_y(n)), m_snap[n / (CS * CS)] ? 3'b111 : 3'b000}));
          if (pix.ready) begin
            n++;
            if (n == NPIX) ph = 2;
          end
        end
        default: begin
          chk("done_pulse", 64'({pix.plot, busy, done}), 64'b011);
          ph = 0;
        end
      endcase
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic wait_done(input bit rnd);
    int k = 0;
    while (!done && k < 20000) begin
      tick();
      if (rnd) pix.ready = 1'($urandom_range(0, 1));
      k++;
    end
    pix.ready = 1;
    chk("done_seen", 64'(done), 64'd1);
    tick();
  endtask
  task automatic rand_board();
    for (int i = 0; i < 200; i++) board[i] = 1'($urandom_range(0, 1));
  endtask
  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int d0, k;
    pix.ready = 1;
    repeat (3) tick();
    chk("reset_xy", 64'({pix.x, pix.y, pix.colour}), 64'd0);
    chk("reset_busy", 64'({busy, done, pix.plot}), 64'd0);
    resetn = 1;
    tick();
    board = '0;
    pulse_start();
    wait_done(0);
    chk("t1_plots", s_plots, NPIX);
    chk("t1_first_x", s_fx, 60);
    chk("t1_first_y", s_fy, 20);
    chk("t1_last_x", s_lx, 99);
    chk("t1_last_y", s_ly, 99);
    chk("t1_busy_cycles", s_busy, 3201);
    chk("t1_done_cycle", s_done_cyc, 3201);
    chk("t1_fill", s_fill, 0);
    chk("t1_dup", s_dup, 0);
    board = '0;
    board[0] = 1'b1;
    pulse_start();
    wait_done(0);
    chk("t2_fill", s_fill, 16);
    chk("t2_fill_first", s_fill_first, 0);
    chk("t2_fill_last", s_fill_last, 15);
    board = '0;
    board[199] = 1'b1;
    pulse_start();
    wait_done(0);
    chk("t3_fill", s_fill, 16);
    chk("t3_fill_first", s_fill_first, 3184);
    chk("t3_fill_last", s_fill_last, 3199);
    rand_board();
    pulse_start();
    repeat (98) tick();
    pix.ready = 0;
    repeat (5) tick();
    pix.ready = 1;
    wait_done(0);
    chk("t4_plot_cycles", s_plot_cyc, 3205);
    chk("t4_plots", s_plots, NPIX);
    chk("t4_dup", s_dup, 0);
    chk("t4_busy_cycles", s_busy, 3206);
    rand_board();
    pulse_start();
    wait_done(1);
    chk("t4r_plots", s_plots, NPIX);
    chk("t4r_dup", s_dup, 0);
    board = '0;
    d0 = done_total;
    pulse_start();
    repeat (9) tick();
    board = '1;
    start = 1;
    tick();
    start = 0;
    wait_done(0);
    repeat (5) tick();
    chk("t5_fill", s_fill, 0);
    chk("t5_plots", s_plots, NPIX);
    chk("t5_done_count", done_total - d0, 1);
    pulse_start();
    wait_done(0);
    chk("t5_fresh_fill", s_fill, NPIX);
    rand_board();
    d0 = done_total;
    pulse_start();
    k = 0;
    while (s_plots < 1000 && k < 5000) begin
      tick();
      k++;
    end
    chk("t6_reached_1000", s_plots, 1000);
    #2 resetn = 0;
    #1;
    chk("t6_async_flags", 64'({pix.plot, busy, done}), 64'd0);
    repeat (3) tick();
    resetn = 1;
    tick();
    chk("t6_no_done", done_total - d0, 0);
    pulse_start();
    wait_done(0);
    chk("t6_plots", s_plots, NPIX);
    chk("t6_first_x", s_fx, 60);
    chk("t6_first_y", s_fy, 20);
    chk("t6_dup", s_dup, 0);
    tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
